// File: rtl/ddr3_rx_dq_lane_align.sv
// ddr3_rx_dq_lane_align
// Read-path word aligner and delay trainer for one DDR3 DQ lane IOD.
// Searches for PATTERN by bit-slipping through every rotation, then stepping
// the input delay line one tap at a time.
// Once locked, it forwards the registered RX data with a valid flag.
// Optional feature: define DDR3_RX_ALIGN_ERRCNT_EN to add ERR_COUNT. This
// output counts the mismatching words seen while LOCKED and is used for eye
// monitoring.
module ddr3_rx_dq_lane_align #(
   parameter int                 WIDTH      = 8,
   parameter logic [WIDTH-1:0]   PATTERN    = 8'h1B,
   parameter int                 SETTLE_CYC = 8,
   parameter int                 MATCH_CNT  = 16,
   parameter int                 MAX_TAPS   = 127,
   parameter int                 TAP_W      = 7,
   localparam int                SLIP_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic                  FAB_CLK,
   input  logic                  ARST_N,
   input  logic [WIDTH-1:0]      RX_DATA_IN,
   input  logic                  TRAIN_START,
   input  logic                  DELAY_LINE_OUT_OF_RANGE,
   output logic                  RX_BIT_SLIP,
   output logic                  DELAY_LINE_LOAD,
   output logic                  DELAY_LINE_MOVE,
   output logic                  DELAY_LINE_DIRECTION,
   output logic [WIDTH-1:0]      RX_DATA_OUT,
   output logic                  RX_DATA_VALID,
   output logic                  TRAIN_BUSY,
   output logic                  TRAIN_DONE,
   output logic                  TRAIN_FAIL,
`ifdef DDR3_RX_ALIGN_ERRCNT_EN
   output logic [15:0]           ERR_COUNT,
`endif
   output logic [SLIP_W-1:0]     SLIP_COUNT,
   output logic [TAP_W-1:0]      TAP_COUNT
);

   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int MCH_W = $clog2(MATCH_CNT + 1);

   localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
   localparam logic [MCH_W-1:0]  MATCH_LAST  = MCH_W'(MATCH_CNT - 1);
   localparam logic [SLIP_W-1:0] SLIP_LAST   = SLIP_W'(WIDTH - 1);
   localparam logic [TAP_W-1:0]  TAP_LAST    = TAP_W'(MAX_TAPS);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_SLIP, S_MOVE, S_LOCKED, S_FAIL
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [SET_W-1:0]    r_settle_cnt;
   logic [MCH_W-1:0]    r_match_cnt;
   logic [SLIP_W-1:0]   r_slip_cnt;
   logic [TAP_W-1:0]    r_tap_cnt;
   logic [WIDTH-1:0]    r_rx_data;
   logic                w_match;
   logic                w_restart;

   assign w_match   = (RX_DATA_IN == PATTERN);
   // A new training run is accepted only from the resting states.
   assign w_restart = TRAIN_START &&
                      ((r_state == S_IDLE) || (r_state == S_LOCKED) || (r_state == S_FAIL));

   // State register.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Next-state decode: slip through every rotation first, then step a tap.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_LOCKED, S_FAIL: begin
            if (TRAIN_START) w_next = S_LOAD;
         end
         S_LOAD:   w_next = S_SETTLE;
         S_SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) w_next = S_CHECK;
         end
         S_CHECK: begin
            if (w_match) begin
               if (r_match_cnt == MATCH_LAST) w_next = S_LOCKED;
            end else if (r_slip_cnt < SLIP_LAST) begin
               w_next = S_SLIP;
            end else if (DELAY_LINE_OUT_OF_RANGE || (r_tap_cnt == TAP_LAST)) begin
               w_next = S_FAIL;
            end else begin
               w_next = S_MOVE;
            end
         end
         S_SLIP, S_MOVE: w_next = S_SETTLE;
         default:        w_next = S_IDLE;
      endcase
   end

   // Settle, match, slip and tap counters; all cleared when training (re)starts.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         r_settle_cnt <= '0;
         r_match_cnt  <= '0;
         r_slip_cnt   <= '0;
         r_tap_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_LOCKED, S_FAIL: begin
               if (w_restart) begin
                  r_settle_cnt <= '0;
                  r_match_cnt  <= '0;
                  r_slip_cnt   <= '0;
                  r_tap_cnt    <= '0;
               end
            end
            S_LOAD:   r_settle_cnt <= '0;
            S_SETTLE: r_settle_cnt <= r_settle_cnt + SET_W'(1);
            S_CHECK: begin
               if (w_match) r_match_cnt <= r_match_cnt + MCH_W'(1);
               else         r_match_cnt <= '0;
            end
            S_SLIP: begin
               r_slip_cnt   <= r_slip_cnt + SLIP_W'(1);
               r_settle_cnt <= '0;
            end
            S_MOVE: begin
               // The IOD rotation has wrapped, so a new tap starts from slip 0.
               r_tap_cnt    <= r_tap_cnt + TAP_W'(1);
               r_slip_cnt   <= '0;
               r_settle_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   // One-cycle data pipeline from the IOD to the controller datapath.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) r_rx_data <= '0;
      else         r_rx_data <= RX_DATA_IN;
   end

`ifdef DDR3_RX_ALIGN_ERRCNT_EN
   logic [15:0] r_err_cnt;

   // Saturating count of bad words while locked, cleared on a new training run.
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         r_err_cnt <= '0;
      end else if (w_restart) begin
         r_err_cnt <= '0;
      end else if ((r_state == S_LOCKED) && !w_match && (r_err_cnt != 16'hFFFF)) begin
         r_err_cnt <= r_err_cnt + 16'd1;
      end
   end

   assign ERR_COUNT = r_err_cnt;
`endif

   // Pulses and status decode directly from the state, so they drop with reset.
   assign DELAY_LINE_LOAD      = (r_state == S_LOAD);
   assign RX_BIT_SLIP          = (r_state == S_SLIP);
   assign DELAY_LINE_MOVE      = (r_state == S_MOVE);
   assign DELAY_LINE_DIRECTION = (r_state == S_MOVE);
   assign TRAIN_BUSY           = (r_state == S_LOAD) || (r_state == S_SETTLE) ||
                                 (r_state == S_CHECK) || (r_state == S_SLIP) ||
                                 (r_state == S_MOVE);
   assign TRAIN_DONE           = (r_state == S_LOCKED);
   assign TRAIN_FAIL           = (r_state == S_FAIL);
   assign RX_DATA_VALID        = (r_state == S_LOCKED);
   assign RX_DATA_OUT          = r_rx_data;
   assign SLIP_COUNT           = r_slip_cnt;
   assign TAP_COUNT            = r_tap_cnt;

endmodule

// File: tb/tb_ddr3_rx_dq_lane_align.sv
// Self-checking bench for ddr3_rx_dq_lane_align with a behavioural IOD model.
module tb_ddr3_rx_dq_lane_align;

   localparam logic [7:0] PAT = 8'h1B;

   logic       FAB_CLK = 1'b0;
   logic       ARST_N  = 1'b0;
   logic [7:0] RX_DATA_IN = '0;
   logic       TRAIN_START = 1'b0;
   logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
   logic       RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
   logic [7:0] RX_DATA_OUT;
   logic       RX_DATA_VALID, TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL;
   logic [2:0] SLIP_COUNT;
   logic [6:0] TAP_COUNT;
`ifdef DDR3_RX_ALIGN_ERRCNT_EN
   logic [15:0] ERR_COUNT;
`endif

   ddr3_rx_dq_lane_align dut (
      .FAB_CLK                 (FAB_CLK),
      .ARST_N                  (ARST_N),
      .RX_DATA_IN              (RX_DATA_IN),
      .TRAIN_START             (TRAIN_START),
      .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
      .RX_BIT_SLIP             (RX_BIT_SLIP),
      .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
      .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
      .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
      .RX_DATA_OUT             (RX_DATA_OUT),
      .RX_DATA_VALID           (RX_DATA_VALID),
      .TRAIN_BUSY              (TRAIN_BUSY),
      .TRAIN_DONE              (TRAIN_DONE),
      .TRAIN_FAIL              (TRAIN_FAIL),
`ifdef DDR3_RX_ALIGN_ERRCNT_EN
      .ERR_COUNT               (ERR_COUNT),
`endif
      .SLIP_COUNT              (SLIP_COUNT),
      .TAP_COUNT               (TAP_COUNT)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   int n_cmp = 0;
   int n_err = 0;

   // IOD model state
   int         rot, n_slip, n_move, n_load, since_load;
   int         good_after, oor_at, glitch_at;
   logic [7:0] base;
   logic       ovr_en;
   logic [7:0] ovr_word;
   logic [7:0] sb_q[$];

   typedef struct {
      logic [7:0] base;
      int         good_after;
      int         oor_at;
      int         e_slips;
      int         e_moves;
      int         e_tap;
      int         e_slipc;
      logic       e_done;
   } scen_t;

   typedef struct {
      logic [7:0] word;
      int         bad;
   } lockv_t;

   scen_t  scen[4];
   lockv_t lockv[8];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      logic [7:0] r;
      r = v;
      for (int i = 0; i < (n % 8); i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   // One fabric cycle: sample outputs on the falling edge, update the IOD model,
   // compare the data pipeline against the scoreboard and drive the next inputs.
   task automatic step(input logic start);
      int         pulses;
      logic [7:0] w;
      @(negedge FAB_CLK);
      pulses = int'(RX_BIT_SLIP) + int'(DELAY_LINE_LOAD) + int'(DELAY_LINE_MOVE);
      if (pulses != 0) check("one_pulse", pulses, 1);
      if (RX_BIT_SLIP) begin
         rot = (rot + 1) % 8;
         n_slip++;
      end
      if (DELAY_LINE_MOVE) begin
         n_move++;
         check("move_dir", DELAY_LINE_DIRECTION, 1);
      end
      if (DELAY_LINE_LOAD) begin
         n_load++;
         since_load = 0;
      end else if (since_load < 100000) begin
         since_load++;
      end
      if (sb_q.size() > 0) check("data_out", RX_DATA_OUT, sb_q.pop_front());
      if (n_move < good_after) w = 8'h00;
      else                     w = rotl(base, rot);
      if ((n_load == 1) && (since_load == glitch_at)) w = 8'h00;
      if (ovr_en) w = ovr_word;
      RX_DATA_IN = w;
      sb_q.push_back(w);
      DELAY_LINE_OUT_OF_RANGE = (oor_at >= 0) && (n_move >= oor_at);
      TRAIN_START = start;
   endtask

   task automatic do_reset();
      ARST_N = 1'b0;
      TRAIN_START = 1'b0;
      RX_DATA_IN = '0;
      DELAY_LINE_OUT_OF_RANGE = 1'b0;
      sb_q.delete();
      rot = 0; n_slip = 0; n_move = 0; n_load = 0; since_load = 100000;
      good_after = 0; oor_at = -1; glitch_at = -1; base = PAT;
      ovr_en = 1'b0; ovr_word = '0;
      repeat (2) @(negedge FAB_CLK);
      ARST_N = 1'b1;
   endtask

   task automatic check_zero(input string nm);
      check(nm, {RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                 RX_DATA_OUT, RX_DATA_VALID, TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL,
                 SLIP_COUNT, TAP_COUNT}, 0);
`ifdef DDR3_RX_ALIGN_ERRCNT_EN
      check({nm, "_err"}, ERR_COUNT, 0);
`endif
   endtask

   // Start training and run until it resolves or the cycle budget runs out.
   task automatic run_train(input int budget);
      int cyc;
      cyc = 0;
      step(1'b1);
      step(1'b0);
      check("busy_load", {TRAIN_BUSY, DELAY_LINE_LOAD}, 2'b11);
      while (!(TRAIN_DONE || TRAIN_FAIL) && (cyc < budget)) begin
         step(1'b0);
         cyc++;
      end
      if (cyc >= budget) check("train_timeout", 1, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s_n, s_m, exp_err;

      // base: word delivered at rotation 0; rotl(PAT,5) needs 3 slips to align.
      // A tap phase walks slip 0..7 with 7 slips, then moves, so N moves cost N*7 slips.
      scen[0] = '{rotl(PAT, 5), 0,    -1, 3,   0,   0,   3, 1'b1};
      scen[1] = '{rotl(PAT, 5), 5,    -1, 35,  5,   5,   0, 1'b1};
      scen[2] = '{PAT,          1000, 20, 147, 20,  20,  7, 1'b0};
      scen[3] = '{PAT,          1000, -1, 896, 127, 127, 7, 1'b0};

      lockv[0] = '{8'h55, 1};
      lockv[1] = '{PAT,   0};
      lockv[2] = '{8'h00, 1};
      lockv[3] = '{8'h36, 1};
      lockv[4] = '{PAT,   0};
      lockv[5] = '{8'hC3, 1};
      lockv[6] = '{PAT,   0};
      lockv[7] = '{PAT,   0};

      do_reset();
      check_zero("reset_state");

      // Training scenarios from the table
      for (int i = 0; i < 4; i++) begin
         do_reset();
         base = scen[i].base;
         good_after = scen[i].good_after;
         oor_at = scen[i].oor_at;
         run_train(20000);
         check($sformatf("s%0d_done", i),  TRAIN_DONE, scen[i].e_done);
         check($sformatf("s%0d_fail", i),  TRAIN_FAIL, !scen[i].e_done);
         check($sformatf("s%0d_valid", i), RX_DATA_VALID, scen[i].e_done);
         check($sformatf("s%0d_busy", i),  TRAIN_BUSY, 0);
         check($sformatf("s%0d_slips", i), n_slip, scen[i].e_slips);
         check($sformatf("s%0d_moves", i), n_move, scen[i].e_moves);
         check($sformatf("s%0d_tap", i),   TAP_COUNT, scen[i].e_tap);
         check($sformatf("s%0d_slipc", i), SLIP_COUNT, scen[i].e_slipc);
         check($sformatf("s%0d_loads", i), n_load, 1);
         s_n = n_slip;
         s_m = n_move;
         repeat (20) step(1'b0);
         check($sformatf("s%0d_quiet", i), {n_slip, n_move}, {s_n, s_m});
         check($sformatf("s%0d_hold", i), {TRAIN_DONE, TRAIN_FAIL},
               {scen[i].e_done, !scen[i].e_done});
      end

      // Single bad word at the 10th compare restarts the search
      do_reset();
      glitch_at = 18;
      step(1'b1);
      for (int k = 0; k < 30; k++) begin
         step(1'b0);
         if (since_load == 19) check("glitch_slip", {RX_BIT_SLIP, n_slip}, {1'b1, 32'd1});
         if (since_load == 25) check("glitch_nolock", TRAIN_DONE, 0);
      end
      for (int k = 0; (k < 2000) && !TRAIN_DONE; k++) step(1'b0);
      check("glitch_done", TRAIN_DONE, 1);
      check("glitch_counts", {n_slip, n_move}, {32'd8, 32'd1});
      check("glitch_regs", {TAP_COUNT, SLIP_COUNT}, {7'd1, 3'd1});

      // Async reset in SETTLE, then TRAIN_START ignored mid-CHECK
      do_reset();
      step(1'b1);
      repeat (4) step(1'b0);
      check("pre_rst_busy", TRAIN_BUSY, 1);
      #2 ARST_N = 1'b0;
      #1 check_zero("async_rst");
      do_reset();
      step(1'b1);
      for (int k = 0; k < 26; k++) begin
         step(1'b0);
         if (since_load == 12) TRAIN_START = 1'b1;
         if (since_load == 24) check("lock_early", TRAIN_DONE, 0);
         if (since_load == 25) check("lock_time", {TRAIN_DONE, RX_DATA_VALID}, 2'b11);
      end
      check("start_ignored", n_load, 1);

      // Bad words while locked keep lock and feed the error counter
      exp_err = 0;
      ovr_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ovr_word = lockv[i].word;
         exp_err += lockv[i].bad;
         step(1'b0);
         check($sformatf("lock_hold%0d", i), {TRAIN_DONE, RX_DATA_VALID}, 2'b11);
      end
      ovr_en = 1'b0;
      step(1'b0);
      step(1'b0);
      check("lock_after_bad", {TRAIN_DONE, RX_DATA_VALID}, 2'b11);
`ifdef DDR3_RX_ALIGN_ERRCNT_EN
      check("err_count", ERR_COUNT, exp_err);
`endif
      step(1'b1);
      step(1'b0);
      check("relock_load", {DELAY_LINE_LOAD, RX_DATA_VALID, TRAIN_DONE}, 3'b100);
`ifdef DDR3_RX_ALIGN_ERRCNT_EN
      check("err_clear", ERR_COUNT, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
